// File: rtl/realnet_arb_pkg.sv
// Shared types and constants for realnet_arbiter. Define REALNET_ARB_CDS to use the
// Cadence wrealavg-resolved nettype; otherwise realnet is a plain real.
`ifndef wrealZState
`define wrealZState 1.0e300
`endif

package realnet_arb_pkg;

`ifdef REALNET_ARB_CDS
    import cds_rnm_pkg::*;
    nettype real realnet with CDS_res_wrealavg;
`else
    typedef real realnet;
`endif

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StGap   = 2'd2
    } arb_state_e;

    localparam real REALNET_Z = `wrealZState;

endpackage

// File: rtl/realnet_rr_picker.sv
// Rotating-priority encoder: the search starts one past ptr, so the last winner
// has the lowest priority on the next pick.
module realnet_rr_picker
    import realnet_arb_pkg::*;
#(
    parameter int unsigned N    = 2,
    parameter int unsigned IdxW = 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [IdxW-1:0] win,
    output logic            valid
);

    logic [IdxW-1:0] idx;

    always_comb begin
        win   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = IdxW'((32'(ptr) + i) % N);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                win   = idx;
            end
        end
    end

endmodule

// File: rtl/realnet_arbiter.sv
// Single-driver arbiter for a shared real net with break-before-make gap and
// round-robin fairness. Define REALNET_ARB_TIMEOUT_EN for forced release after MAX_HOLD.
module realnet_arbiter
    import realnet_arb_pkg::*;
#(
    parameter int unsigned N        = 2,
    parameter int unsigned GAP      = 1,
    parameter int unsigned MAX_HOLD = 16,
    localparam int unsigned IdxW    = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  real             val [N],
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] gnt_id,
    output logic            busy,
    output realnet          bus
);

    if (N < 2 || N > 8) begin : g_bad_n
        $error("realnet_arbiter: N out of range");
    end
    if (GAP < 1 || GAP > 15) begin : g_bad_gap
        $error("realnet_arbiter: GAP out of range");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("realnet_arbiter: MAX_HOLD out of range");
    end

    localparam logic [3:0] GapLd = 4'(GAP);

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] gnt_id_q, gnt_id_d;
    logic [3:0]      gap_q, gap_d;
    logic [IdxW-1:0] pick_win;
    logic            pick_valid;
    logic            take;
    logic [N-1:0]    holder_oh;
    real             bus_val;

`ifdef REALNET_ARB_TIMEOUT_EN
    localparam logic [7:0] HoldMax = 8'(MAX_HOLD);
    logic [7:0] hold_q, hold_d;
    logic       others_req;
    assign others_req = |(req & ~holder_oh);
`endif

    assign holder_oh = N'(1) << gnt_id_q;

    realnet_rr_picker #(
        .N    (N),
        .IdxW (IdxW)
    ) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .win   (pick_win),
        .valid (pick_valid)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_id_d = gnt_id_q;
        gap_d    = gap_q;
        take     = 1'b0;
`ifdef REALNET_ARB_TIMEOUT_EN
        hold_d   = hold_q;
`endif
        case (state_q)
            StIdle: begin
                take = pick_valid;
            end
            StGrant: begin
                if (!req[gnt_id_q]) begin
                    state_d = StGap;
                    gap_d   = GapLd;
                end
`ifdef REALNET_ARB_TIMEOUT_EN
                else begin
                    if (hold_q < HoldMax) hold_d = hold_q + 8'd1;
                    // Saturated holder yields only when someone else is waiting.
                    if (hold_d == HoldMax && others_req) begin
                        state_d = StGap;
                        gap_d   = GapLd;
                    end
                end
`endif
            end
            StGap: begin
                gap_d = gap_q - 4'd1;
                if (gap_q <= 4'd1) begin
                    gap_d = '0;
                    if (pick_valid) take = 1'b1;
                    else            state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (take) begin
            state_d  = StGrant;
            ptr_d    = pick_win;
            gnt_id_d = pick_win;
`ifdef REALNET_ARB_TIMEOUT_EN
            hold_d   = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ptr_q    <= IdxW'(N - 1);
            gnt_id_q <= '0;
            gap_q    <= '0;
`ifdef REALNET_ARB_TIMEOUT_EN
            hold_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_id_q <= gnt_id_d;
            gap_q    <= gap_d;
`ifdef REALNET_ARB_TIMEOUT_EN
            hold_q   <= hold_d;
`endif
        end
    end

    assign gnt    = (state_q == StGrant) ? holder_oh : '0;
    assign gnt_id = gnt_id_q;
    assign busy   = (state_q == StGrant) || (state_q == StGap);

    always_comb begin
        bus_val = REALNET_Z;
        if (state_q == StGrant) bus_val = val[gnt_id_q];
    end

    assign bus = bus_val;

endmodule

// File: tb/tb_realnet_arbiter.sv
// Randomized self-checking bench for realnet_arbiter against a behavioural model.
module tb_realnet_arbiter;
    import realnet_arb_pkg::*;

    localparam int N        = 4;
    localparam int GAP      = 3;
    localparam int MAX_HOLD = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    real          val [N];
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         busy;
    realnet       bus;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: holder index (-1 none), remaining gap cycles, rr pointer.
    int m_holder, m_gap, m_ptr, m_id, m_hold;

    realnet_arbiter #(
        .N        (N),
        .GAP      (GAP),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .val    (val),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_holder = -1;
        m_gap    = 0;
        m_ptr    = N - 1;
        m_id     = 0;
        m_hold   = 0;
    endfunction

    function automatic void model_pick();
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (m_ptr + i) % N;
            if (req[c]) begin
                m_holder = c;
                m_ptr    = c;
                m_id     = c;
                m_hold   = 0;
                return;
            end
        end
    endfunction

    function automatic void model_step();
        if (m_holder >= 0) begin
            if (!req[m_holder]) begin
                m_holder = -1;
                m_gap    = GAP;
            end
`ifdef REALNET_ARB_TIMEOUT_EN
            else begin
                if (m_hold < MAX_HOLD) m_hold++;
                if (m_hold == MAX_HOLD && (req & ~(N'(1) << m_holder)) != 0) begin
                    m_holder = -1;
                    m_gap    = GAP;
                end
            end
`endif
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0 && req != 0) model_pick();
        end else if (req != 0) begin
            model_pick();
        end
    endfunction

    function automatic real exp_bus();
        return (m_holder >= 0) ? val[m_holder] : REALNET_Z;
    endfunction

    task automatic check_outputs();
        logic [N-1:0] eg;
        eg = (m_holder >= 0) ? (N'(1) << m_holder) : '0;
        check("gnt", 64'(gnt), 64'(eg));
        check("gnt_id", 64'(gnt_id), 64'(m_id));
        check("busy", 64'(busy), 64'((m_holder >= 0) || (m_gap > 0)));
        check("bus", $realtobits(bus), $realtobits(exp_bus()));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    // Call shortly after an edge; pulses reset well clear of the next edge.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1 model_reset();
        check_outputs();
        req = '0;
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_grant(input string tag);
        int n;
        n = 0;
        while (gnt == '0 && n < 40) begin
            cycle();
            n++;
        end
        if (gnt == '0) check({tag, "_timeout"}, 64'(0), 64'(1));
    endtask

    int order [5];
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int zc, hc;

    initial begin
        for (int i = 0; i < N; i++) val[i] = 0.5 * (i + 1);
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_outputs();
        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_bus", $realtobits(bus), $realtobits(REALNET_Z));
        rst_n = 1'b1;

        // Single requester: one-cycle latency, zero-delay value tracking.
        req = 4'b0001;
        val[0] = 2.2;
        cycle();
        check("t1_gnt", 64'(gnt), 64'(4'b0001));
        check("t1_bus", $realtobits(bus), $realtobits(2.2));
        val[0] = 3.3;
        #0;
        #1 check("t1_bus_0dly", $realtobits(bus), $realtobits(3.3));
        req = '0;
        repeat (GAP + 2) cycle();

        // Simultaneous requests after reset, then handover with exact Z gap.
        do_reset();
        req = 4'b0011;
        val[0] = 2.2;
        val[1] = 1.1;
        cycle();
        check("t2_gnt0", 64'(gnt), 64'(4'b0001));
        req = 4'b0010;
        cycle();
        zc = 0;
        while (gnt == '0 && zc < 20) begin
            check("t2_busy", 64'(busy), 64'(1));
            check("t2_busz", $realtobits(bus), $realtobits(REALNET_Z));
            zc++;
            cycle();
        end
        check("t2_gapcycles", 64'(zc), 64'(GAP));
        check("t2_gnt1", 64'(gnt), 64'(4'b0010));
        check("t2_bus1", $realtobits(bus), $realtobits(1.1));
        req = '0;
        repeat (GAP + 2) cycle();

        // All requesting, each holder releases after two grant cycles.
        do_reset();
        req = '1;
        for (int g = 0; g < 5; g++) begin
            wait_grant("t3");
            order[g] = int'(gnt_id);
            cycle();
            req[gnt_id] = 1'b0;
            cycle();
            req = '1;
        end
        for (int g = 0; g < 5; g++) check($sformatf("t3_order%0d", g), 64'(order[g]),
                                          64'(exp_order[g]));

        // Asynchronous reset mid-grant.
        wait_grant("t4");
        #2 rst_n = 1'b0;
        #1 model_reset();
        check("t4_gnt", 64'(gnt), 64'(0));
        check("t4_bus", $realtobits(bus), $realtobits(REALNET_Z));
        check_outputs();
        #1 rst_n = 1'b1;
        cycle();
        check("t4_regrant", 64'(gnt_id), 64'(0));
        check("t4_regnt", 64'(gnt), 64'(4'b0001));
        req = '0;
        repeat (GAP + 2) cycle();

`ifdef REALNET_ARB_TIMEOUT_EN
        do_reset();
        req = 4'b0011;
        hc = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (gnt == 4'b0001) hc++;
            else if (hc > 0) break;
        end
        check("t5_forced", 64'(hc), 64'(MAX_HOLD));
        do_reset();
        req = 4'b0001;
        hc = 0;
        for (int i = 0; i < 21; i++) begin
            cycle();
            if (gnt == 4'b0001) hc++;
        end
        check("t5_hold", 64'(hc), 64'(21));
        req = '0;
        repeat (GAP + 2) cycle();
`endif

        // Random traffic with slowly changing requests and values.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            cycle();
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
                if ($urandom_range(0, 2) == 0) val[i] = real'($urandom_range(0, 1000)) / 100.0;
            end
            #1 check("rnd_bus_0dly", $realtobits(bus), $realtobits(exp_bus()));
            if ($urandom_range(0, 99) == 0) begin
                #1 rst_n = 1'b0;
                #1 model_reset();
                check_outputs();
                #1 rst_n = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/realnet_arbiter.md
# realnet_arbiter

Arbitrates N real-valued drivers for one shared `realnet` (nettype with `CDS_res_wrealavg` resolution). At most one requester drives the net at a time; every other driver sits at `` `wrealZState``, so the net carries a single clean value instead of an average. Enforces break-before-make gap cycles and round-robin fairness. Sits between the analog-model drivers and the shared net in RNM top levels.

## Interface
Parameters:
- `N`, 2: number of requesters (2..8)
- `GAP`, 1: Z cycles between successive grants (1..15)
- `MAX_HOLD`, 16: grant cycles before forced release (only with the timeout feature; 1..255)

Ports (one clock `clk`; reset `rst_n` is asynchronous, active-low):
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `req`  in  N  request per driver, level-sensitive
- `val`  in  real[N]  value each driver wants on the net
- `gnt`  out  N  one-hot grant, all-zero when idle or in gap
- `gnt_id`  out  $clog2(N)  index of current/last grantee
- `busy`  out  1  high in GRANT or GAP
- `bus`  out  realnet  shared net

## Operation
- States: IDLE, GRANT, GAP.
- IDLE: `bus` = `` `wrealZState``, `gnt` = 0. On a posedge with any `req` bit set, the picker selects a winner. Next state is GRANT, `gnt[w]` = 1, `gnt_id` = w.
- GRANT: `bus` follows `val[gnt_id]` continuously. A `val` change is visible on `bus` with zero delay.
- Release: a posedge that samples `req[gnt_id]` = 0 moves the block to GAP, clears `gnt`, and sets `bus` to Z.
- GAP: lasts exactly `GAP` cycles using a 4-bit down-counter. At expiry:
  - If any `req` bit is set, the block grants the next winner directly (GAP to GRANT).
  - Otherwise it returns to IDLE.
- Round-robin: the search starts at `gnt_id+1` (mod N). After reset the pointer makes index 0 highest priority. The current holder has lowest priority for the next pick.
- A request that drops before it is granted is ignored. No request is latched.
- A holder that re-raises `req` during GAP competes normally at the lowest priority.
- Illegal state: recovers to IDLE.

## Timing
- Reset values: `gnt` = 0, `gnt_id` = 0, `busy` = 0, `bus` = Z, state = IDLE, pointer = N-1, counters = 0.
- Assertion of `rst_n` acts immediately and asynchronously, including mid-grant. `bus` goes Z in the same timestep.
- Grant latency: `req` rising before edge k gives `gnt` high after edge k (1 cycle from IDLE).
- Handover: the holder drops `req` before edge k. `gnt` falls after edge k. The next `gnt` rises after edge k+GAP. `bus` is Z for exactly GAP cycles.
- Simultaneous requests at the same edge: round-robin order decides.

## Configuration
- `REALNET_ARB_TIMEOUT_EN` defined:
  - An 8-bit hold counter increments each GRANT cycle.
  - When the counter reaches `MAX_HOLD` and another `req` bit is set, the block forces release into GAP even if the holder keeps `req` high.
  - If no other requester is waiting, the counter saturates and the grant holds.
  - The counter clears on entry to GRANT.
- Undefined: no hold counter. The holder keeps the net until it drops `req`. `MAX_HOLD` is unused.

## Structure
- Package `realnet_arb_pkg` holds:
  - `nettype real realnet with CDS_res_wrealavg` (imports `cds_rnm_pkg`)
  - state enum `arb_state_e`
  - constant `REALNET_Z` = `` `wrealZState``
- Sub-module `realnet_rr_picker`: combinational rotate-priority-encoder. Inputs are `req` and pointer; outputs are winner index and a valid flag.
- `bus` is driven by a single continuous assign from an internal real (`val[gnt_id]` in GRANT, else `REALNET_Z`).

## Test plan
- N=2, GAP=1. Reset, then `req` = 2'b01 with `val[0]` = 2.2 → `gnt` = 01 after 1 edge, `bus` = 2.2; `val[0]` changes to 3.3 → `bus` = 3.3 in the same timestep.
- Both request at the same edge after reset → `gnt` = 01. `req[0]` drops → 1 Z cycle, then `gnt` = 10 and `bus` = 1.1. The net never reads 1.65 (average).
- GAP=3, handover 0→1 → `busy` stays high and `bus` = Z for exactly 3 cycles.
- N=4, all `req` held high, holder releases after 2 cycles each time → grant order 0,1,2,3,0.
- `rst_n` pulsed low mid-grant → `gnt` = 0 and `bus` = Z immediately. After release the next grant goes to index 0.
- With `REALNET_ARB_TIMEOUT_EN`, MAX_HOLD=4: `req[0]` held, `req[1]` raised → forced release after 4 grant cycles. With only `req[0]` high → grant holds for 20 cycles.
